writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width.
REQ-002 SHALL have parameter NUM_REGS, default 4, register count; the address width is log2(NUM_REGS) = 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, memory-result buffer depth.
REQ-004 SHALL use one clock, Clock; reset Reset_n is asynchronous and active-low.
REQ-005 Ports, as name, direction, width, meaning:
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  async active-low reset.
- AluValid  in  1  ALU result present this cycle.
- AluRd  in  2  ALU destination register.
- AluData  in  DATA_W  ALU result.
- MemValid  in  1  load result offered.
- MemRd  in  2  load destination register.
- MemData  in  DATA_W  load data.
- MemReady  out  1  load result accepted when MemValid&&MemReady.
- LoadIssue  in  1  load issued; marks its destination pending.
- LoadIssueRd  in  2  destination of issued load.
- Pending  out  NUM_REGS  per-register outstanding-load bit.
- RegWrite  out  1  register-file write enable.
- RD  out  2  register-file write address.
- WriteData  out  DATA_W  register-file write data.
- WawErr  out  1  one-cycle pulse: ALU wrote a pending register.

Function
REQ-006 SHALL register RegWrite, RD and WriteData, so a source selected in cycle N appears on the register-file port in cycle N+1.
REQ-007 SHALL always select AluValid first; when AluValid=0 and the FIFO is non-empty, it SHALL pop the FIFO head; otherwise RegWrite SHALL be 0 next cycle.
REQ-008 SHALL hold RD and WriteData at their last values when RegWrite=0.
REQ-009 SHALL push {MemRd, MemData} into the FIFO when MemValid&&MemReady.
REQ-010 SHALL drive MemReady = (count < FIFO_DEPTH) combinationally from the registered count; when full, MemReady=0 and MemValid SHALL be ignored.
REQ-011 SHALL allow a push and a pop in the same cycle, leaving count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-012 SHALL set Pending[LoadIssueRd] on the edge where LoadIssue=1.
REQ-013 SHALL clear Pending[r] on the edge where a FIFO entry with Rd=r is popped to the write port.
REQ-014 SHALL give set priority when a set and a clear hit the same register in the same cycle, so Pending stays 1.
REQ-015 SHALL pulse WawErr for one cycle, in cycle N+1, when AluValid=1 in cycle N and Pending[AluRd]=1; the ALU write SHALL still occur.
REQ-016 SHALL deliver FIFO entries in acceptance order.
REQ-017 SHALL NOT drop or duplicate an accepted entry under continuous ALU priority; an entry waits until AluValid=0.

Reset
REQ-018 SHALL set the following on Reset_n=0, immediately and asynchronously: RegWrite=0, RD=0, WriteData=0, WawErr=0, Pending=0, FIFO count=0, pointers=0.
REQ-019 SHALL discard any buffered entries on reset mid-operation.
REQ-020 SHALL drive MemReady=1 after reset deasserts.
REQ-021 SHALL begin the first writeback no earlier than the first rising edge after deassertion.

Configuration
REQ-022 SHALL, when WB_BYPASS_EN is defined, route a load result straight to the write-port registers in the cycle it is accepted, bypassing storage, when the FIFO is empty and AluValid=0.
REQ-023 SHALL, without WB_BYPASS_EN, pass every load through the FIFO, giving a minimum load-to-RegWrite latency of 2 cycles (1 cycle with the macro).

Structure
REQ-024 SHALL place DATA_W, NUM_REGS, the register-address width and the FIFO entry typedef {rd, data} in the shared package cpu16_pkg.
REQ-025 SHALL implement the FIFO as sub-module wb_fifo, with push/pop/full/empty/count, instantiated once.

Verification
REQ-026 Scenario: AluValid=1, AluRd=2, AluData=16'h1234 in cycle 0 -> RegWrite=1, RD=2, WriteData=16'h1234 in cycle 1 only.
REQ-027 Scenario: LoadIssue with Rd=1, then MemValid with Rd=1, data 16'hBEEF, with no ALU traffic -> Pending[1]=1 until the write, RegWrite with data 16'hBEEF at +2 cycles (+1 with WB_BYPASS_EN), and Pending[1]=0 on that edge.
REQ-028 Scenario: AluValid held for 4 cycles while 3 loads are offered (Rd=0,1,3) -> MemReady=0 after 2 loads are accepted; after AluValid drops, Rd=0, then 1, then 3 are written in order; no loss.
REQ-029 Scenario: Pending[3]=1 and AluValid with AluRd=3, data 16'h0007 -> WawErr pulses 1 cycle, R3 is written with 16'h0007, and Pending[3] stays 1.
REQ-030 Scenario: in the same cycle, LoadIssue with Rd=0 and a pop of an entry with Rd=0 -> Pending[0]=1 afterwards.
REQ-031 Scenario: FIFO holds 2 entries and Reset_n is pulsed low mid-cycle -> all outputs are 0 immediately, MemReady=1 after release, and no stale writes occur.

Source files
------------

// File: rtl/cpu16_pkg.sv
// ============================================================================
// Package : cpu16_pkg
// Brief   : Shared widths, register-address helper and writeback FIFO entry.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu16_pkg;

  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 4;
  localparam int REG_AW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Address width for n registers, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module : wb_fifo
// Brief  : Small in-order buffer for load results awaiting the write port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_fifo import cpu16_pkg::*; #(
  parameter  int WIDTH = $bits(wb_entry_t),
  parameter  int DEPTH = cpu16_pkg::FIFO_DEPTH,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap explicitly so non-power-of-two depths stay correct.
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge Clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// Module : writeback_unit
// Brief  : Arbitrates ALU and load results onto the register-file write port
//          and tracks outstanding loads per destination register.
// Config : WB_BYPASS_EN - load result goes straight to the write port when
//          the buffer is empty and the ALU is idle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module writeback_unit import cpu16_pkg::*; #(
  parameter  int DATA_W     = cpu16_pkg::DATA_W,
  parameter  int NUM_REGS   = cpu16_pkg::NUM_REGS,
  parameter  int FIFO_DEPTH = cpu16_pkg::FIFO_DEPTH,
  localparam int AW         = addr_w(NUM_REGS),
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                AluValid,
  input  logic [AW-1:0]       AluRd,
  input  logic [DATA_W-1:0]   AluData,
  input  logic                MemValid,
  input  logic [AW-1:0]       MemRd,
  input  logic [DATA_W-1:0]   MemData,
  output logic                MemReady,
  input  logic                LoadIssue,
  input  logic [AW-1:0]       LoadIssueRd,
  output logic [NUM_REGS-1:0] Pending,
  output logic                RegWrite,
  output logic [AW-1:0]       RD,
  output logic [DATA_W-1:0]   WriteData,
  output logic                WawErr
);

  localparam int            EW      = AW + DATA_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic                reg_write_q, reg_write_d;
  logic [AW-1:0]       rd_q,        rd_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic                waw_q,       waw_d;
  logic [NUM_REGS-1:0] pending_q,   pending_d;

  logic              mem_accept, bypass;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]     fifo_head;
  logic [CW-1:0]     fifo_count;
  logic [AW-1:0]     head_rd;
  logic [DATA_W-1:0] head_data;

  assign MemReady   = (fifo_count < DEPTH_C);
  assign mem_accept = MemValid && MemReady;

`ifdef WB_BYPASS_EN
  assign bypass = mem_accept && fifo_empty && !AluValid;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = mem_accept && !bypass && !fifo_full;
  assign fifo_pop  = !AluValid && !fifo_empty;
  assign head_rd   = fifo_head[EW-1 -: AW];
  assign head_data = fifo_head[DATA_W-1:0];

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .push      (fifo_push),
    .push_data ({MemRd, MemData}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    pending_d   = pending_q;
    if (AluValid) begin
      reg_write_d = 1'b1;
      rd_d        = AluRd;
      wdata_d     = AluData;
    end else if (fifo_pop) begin
      reg_write_d        = 1'b1;
      rd_d               = head_rd;
      wdata_d            = head_data;
      pending_d[head_rd] = 1'b0;
    end else if (bypass) begin
      reg_write_d      = 1'b1;
      rd_d             = MemRd;
      wdata_d          = MemData;
      pending_d[MemRd] = 1'b0;
    end
    // Applied after the clear so a same-cycle issue keeps the register pending.
    if (LoadIssue) pending_d[LoadIssueRd] = 1'b1;
  end

  assign waw_d = AluValid && pending_q[AluRd];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
      waw_q       <= 1'b0;
      pending_q   <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      waw_q       <= waw_d;
      pending_q   <= pending_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign RD        = rd_q;
  assign WriteData = wdata_q;
  assign WawErr    = waw_q;
  assign Pending   = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// Module : tb_writeback_unit
// Brief  : Directed and random stimulus for writeback_unit against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_writeback_unit;
  import cpu16_pkg::*;

  localparam int DEPTH = 2;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 2;
`endif

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        AluValid, MemValid, LoadIssue;
  logic [1:0]  AluRd, MemRd, LoadIssueRd;
  logic [15:0] AluData, MemData;
  logic        MemReady, RegWrite, WawErr;
  logic [3:0]  Pending;
  logic [1:0]  RD;
  logic [15:0] WriteData;

  always #5 Clock = ~Clock;

  writeback_unit #(.DATA_W(16), .NUM_REGS(4), .FIFO_DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData),
    .MemValid(MemValid), .MemRd(MemRd), .MemData(MemData), .MemReady(MemReady),
    .LoadIssue(LoadIssue), .LoadIssueRd(LoadIssueRd), .Pending(Pending),
    .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData), .WawErr(WawErr)
  );

  // Reference model: queue of accepted loads, pending bit per register,
  // and the expected contents of the write port after the next edge.
  wb_entry_t   q[$];
  logic [3:0]  pend;
  logic        m_we, m_waw, last_acc;
  logic [1:0]  m_rd;
  logic [15:0] m_data;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend   = '0;
    m_we   = 1'b0;
    m_waw  = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  task automatic idle();
    AluValid  = 1'b0;
    MemValid  = 1'b0;
    LoadIssue = 1'b0;
  endtask

  // One clock: predict from current inputs, advance, then compare.
  task automatic step();
    wb_entry_t e;
    bit ready, acc, byp;
    ready = (q.size() < DEPTH);
    chk("MemReady", MemReady, ready);
    acc   = MemValid && ready;
    byp   = 1'b0;
    m_we  = 1'b0;
    m_waw = 1'b0;
    if (AluValid) begin
      m_we = 1'b1; m_rd = AluRd; m_data = AluData; m_waw = pend[AluRd];
    end else if (q.size() != 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_rd = e.rd; m_data = e.data; pend[e.rd] = 1'b0;
    end else if (BYP && acc) begin
      byp = 1'b1;
      m_we = 1'b1; m_rd = MemRd; m_data = MemData; pend[MemRd] = 1'b0;
    end
    if (acc && !byp) begin
      e.rd = MemRd; e.data = MemData;
      q.push_back(e);
    end
    if (LoadIssue) pend[LoadIssueRd] = 1'b1;
    last_acc = acc;
    @(posedge Clock); #1;
    chk("RegWrite",  RegWrite,  m_we);
    chk("RD",        RD,        m_rd);
    chk("WriteData", WriteData, m_data);
    chk("WawErr",    WawErr,    m_waw);
    chk("Pending",   Pending,   pend);
  endtask

  initial begin : main
    logic [1:0] lrd [3];
    logic [1:0] wr_seq [$];
    int lat, li;
    bit got;

    Reset_n = 1'b0;
    AluRd = '0; AluData = '0; MemRd = '0; MemData = '0; LoadIssueRd = '0;
    idle();
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_RegWrite",  RegWrite,  0);
    chk("rst_RD",        RD,        0);
    chk("rst_WriteData", WriteData, 0);
    chk("rst_WawErr",    WawErr,    0);
    chk("rst_Pending",   Pending,   0);
    chk("rst_MemReady",  MemReady,  1);
    #3 Reset_n = 1'b1;

    // ALU result appears on the port for exactly one cycle
    AluValid = 1'b1; AluRd = 2'd2; AluData = 16'h1234;
    step();
    chk("alu_write", {RegWrite, RD, WriteData}, {1'b1, 2'd2, 16'h1234});
    idle();
    step();
    chk("alu_one_cycle", RegWrite, 0);

    // Load issue, pending tracking and load-to-write latency
    LoadIssue = 1'b1; LoadIssueRd = 2'd1;
    step();
    LoadIssue = 1'b0;
    chk("pend1_set", Pending[1], 1);
    MemValid = 1'b1; MemRd = 2'd1; MemData = 16'hBEEF;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      MemValid = 1'b0;
      lat++;
      if (RegWrite && WriteData == 16'hBEEF) got = 1'b1;
      else chk("pend1_hold", Pending[1], 1);
    end
    chk("load_latency", lat, LAT);
    chk("load_data", WriteData, 16'hBEEF);
    chk("pend1_clr", Pending[1], 0);

    // ALU held busy while three loads are offered; in-order drain, no loss
    lrd[0] = 2'd0; lrd[1] = 2'd1; lrd[2] = 2'd3;
    li = 0;
    for (int c = 0; c < 4; c++) begin
      AluValid = 1'b1; AluRd = 2'($urandom_range(0, 3)); AluData = 16'($urandom);
      MemValid = (li < 3);
      if (li < 3) begin MemRd = lrd[li]; MemData = 16'($urandom); end
      step();
      if (last_acc) li++;
    end
    chk("full_not_ready", MemReady, 0);
    AluValid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      MemValid = (li < 3);
      if (li < 3) MemRd = lrd[li];
      step();
      if (last_acc) li++;
      if (RegWrite) wr_seq.push_back(RD);
    end
    chk("drain_count", wr_seq.size(), 3);
    if (wr_seq.size() == 3) begin
      chk("drain_rd0", wr_seq[0], 0);
      chk("drain_rd1", wr_seq[1], 1);
      chk("drain_rd2", wr_seq[2], 3);
    end
    idle();

    // ALU writes a pending register: one-cycle flag, write still lands
    LoadIssue = 1'b1; LoadIssueRd = 2'd3;
    step();
    LoadIssue = 1'b0;
    AluValid = 1'b1; AluRd = 2'd3; AluData = 16'h0007;
    step();
    chk("waw_pulse", WawErr, 1);
    chk("waw_write", {RegWrite, RD, WriteData}, {1'b1, 2'd3, 16'h0007});
    chk("waw_pend3", Pending[3], 1);
    idle();
    step();
    chk("waw_one_cycle", WawErr, 0);

    // Issue and pop hitting the same register in one cycle: set wins
    AluValid = 1'b1; AluRd = 2'd2; AluData = 16'($urandom);
    MemValid = 1'b1; MemRd = 2'd0; MemData = 16'($urandom);
    step();
    idle();
    LoadIssue = 1'b1; LoadIssueRd = 2'd0;
    step();
    LoadIssue = 1'b0;
    chk("set_wins_pend0", Pending[0], 1);
    chk("set_wins_rd", {RegWrite, RD}, {1'b1, 2'd0});

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      AluValid    = ($urandom_range(0, 9) < 4);
      AluRd       = 2'($urandom_range(0, 3));
      AluData     = 16'($urandom);
      MemValid    = ($urandom_range(0, 1) == 1);
      MemRd       = 2'($urandom_range(0, 3));
      MemData     = 16'($urandom);
      LoadIssue   = ($urandom_range(0, 9) < 3);
      LoadIssueRd = 2'($urandom_range(0, 3));
      step();
    end

    // Reset while two entries are buffered
    idle();
    repeat (3) step();
    AluValid = 1'b1; MemValid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      AluRd = 2'($urandom_range(0, 3)); AluData = 16'($urandom);
      MemRd = 2'($urandom_range(0, 3)); MemData = 16'($urandom);
      step();
    end
    chk("prereset_full", MemReady, 0);
    #3 Reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_RegWrite",  RegWrite,  0);
    chk("mid_rst_RD",        RD,        0);
    chk("mid_rst_WriteData", WriteData, 0);
    chk("mid_rst_WawErr",    WawErr,    0);
    chk("mid_rst_Pending",   Pending,   0);
    #2 Reset_n = 1'b1;
    idle();
    chk("post_rst_MemReady", MemReady, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("no_stale_write", RegWrite, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
